// File: rtl/ape_tile_accum_if.sv
// Handshake bundle for ape_tile_accum: tile start/bias, MPE beat stream and row drain.
// master = producer/consumer side, slave = the accumulate engine.
interface ape_tile_accum_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [1:0]               af_type;
  logic                     bias_load;
  logic [ACC_W-1:0]         bias;
  logic                     mpe_valid;
  logic                     mpe_ready;
  logic                     mpe_last;
  logic [ROWS*COLS*ACC_W-1:0] mpe_vals;
  logic                     out_valid;
  logic                     out_ready;
  logic [RW-1:0]            out_row;
  logic [COLS*OUT_W-1:0]    out_data;
  logic                     busy;
  logic                     sat_flag;

  modport master (
    output af_type, bias_load, bias, mpe_valid, mpe_last, mpe_vals, out_ready,
    input  mpe_ready, out_valid, out_row, out_data, busy, sat_flag
  );

  modport slave (
    input  af_type, bias_load, bias, mpe_valid, mpe_last, mpe_vals, out_ready,
    output mpe_ready, out_valid, out_row, out_data, busy, sat_flag
  );
endinterface

// File: rtl/ape_tile_accum.sv
// Tile accumulator: bias preload, saturating accumulate, then shift/saturate/activate per row drain.
// Optional macro APE_LEAKY_RELU_EN enables leaky ReLU on af_type 2 (otherwise af_type 2 = none).
module ape_tile_accum #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 8,
  parameter int FRAC_BITS = 4
) (
  input logic            clock,
  input logic            reset,
  ape_tile_accum_if.slave bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int N  = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [N];
  logic signed [ACC_W-1:0] acc_d [N];
  logic signed [ACC_W:0]   sum   [N];
  logic signed [ACC_W-1:0] shf   [COLS];
  logic signed [OUT_W-1:0] ysat  [COLS];
  logic [1:0]              af_q;
  logic                    sat_q;
  logic [RW-1:0]           ptr_q;
  logic                    acc_clip, row_sat;
  logic                    start, beat, hs, last_row;

  function automatic logic add_ovf(input logic signed [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (add_ovf(s))
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  // Fits in OUT_W only when all bits above the OUT_W sign bit replicate it.
  function automatic logic out_ovf(input logic signed [ACC_W-1:0] v);
    return !((&v[ACC_W-1:OUT_W-1]) || !(|v[ACC_W-1:OUT_W-1]));
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (out_ovf(v))
      return v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return v[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] activate(input logic signed [OUT_W-1:0] y,
                                                        input logic [1:0] af);
    case (af)
      2'd1:    return y[OUT_W-1] ? '0 : y;
`ifdef APE_LEAKY_RELU_EN
      2'd2:    return y[OUT_W-1] ? (y >>> 3) : y;
`endif
      default: return y;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.bias_load) state_d = ACCUM;
      ACCUM:   if (bus.mpe_valid && bus.mpe_last) state_d = DRAIN;
      DRAIN:   if (bus.out_ready && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mpe_ready = (state_q == ACCUM);
    bus.out_valid = (state_q == DRAIN);
    bus.busy      = (state_q != IDLE);
    bus.out_row   = ptr_q;
    bus.sat_flag  = sat_q;
    start         = (state_q == IDLE) && bus.bias_load;
    beat          = (state_q == ACCUM) && bus.mpe_valid;
    hs            = (state_q == DRAIN) && bus.out_ready;
    last_row      = (ptr_q == RW'(ROWS - 1));
  end

  // Accumulate stage: sign-extended add, clipped back to ACC_W.
  always_comb begin
    acc_clip = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum[i]   = $signed({acc_q[i][ACC_W-1], acc_q[i]}) +
                 $signed({bus.mpe_vals[i*ACC_W + ACC_W - 1], bus.mpe_vals[i*ACC_W +: ACC_W]});
      acc_d[i] = sat_acc(sum[i]);
      acc_clip = acc_clip | add_ovf(sum[i]);
    end
  end

  // Post-process stage: selected row is shifted, saturated and activated combinationally.
  always_comb begin
    row_sat      = 1'b0;
    bus.out_data = '0;
    for (int c = 0; c < COLS; c++) begin
      shf[c]  = acc_q[int'(ptr_q) * COLS + c] >>> FRAC_BITS;
      ysat[c] = sat_out(shf[c]);
      row_sat = row_sat | out_ovf(shf[c]);
      bus.out_data[c*OUT_W +: OUT_W] = activate(ysat[c], af_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) acc_q[i] <= '0;
      af_q  <= '0;
      sat_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      if (start) begin
        for (int i = 0; i < N; i++) acc_q[i] <= bus.bias;
        af_q  <= bus.af_type;
        sat_q <= 1'b0;
        ptr_q <= '0;
      end
      if (beat) begin
        for (int i = 0; i < N; i++) acc_q[i] <= acc_d[i];
        if (acc_clip) sat_q <= 1'b1;
        if (bus.mpe_last) ptr_q <= '0;
      end
      if (hs) begin
        if (row_sat) sat_q <= 1'b1;
        ptr_q <= last_row ? '0 : ptr_q + 1'b1;
      end
    end
  end
endmodule
